// File: rtl/spi_rx_fifo.sv
// SPI receive path: deserialises MISO into DATA_W-bit words and queues them in a
// DEPTH-entry first-word-fall-through FIFO with full/empty/level/overrun status.
module spi_rx_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              CS_ACTIVE,
  input  logic              SAMPLE_STB,
  input  logic              MISO,
  input  logic              LSB_FIRST,
  input  logic              RD_EN,
  input  logic              OVR_CLR,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RXFIFO_FULL,
  output logic              RXFIFO_EMPTY,
  output logic [AW:0]       RX_LEVEL,
  output logic              RX_OVERRUN
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              ovr_q, ovr_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              strobe;
  logic              word_done;
  logic [DATA_W-1:0] push_word;
  logic              full, empty, push, pop, drop;

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] cur,
                                                 input logic              bit_in,
                                                 input logic              lsb_first);
    logic [DATA_W-1:0] nxt;
    if (lsb_first) nxt = {bit_in, cur[DATA_W-1:1]};
    else           nxt = {cur[DATA_W-2:0], bit_in};
    return nxt;
  endfunction

  // Deserialiser: strobes only count while CS is asserted; dropping CS discards the partial word
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    push_word = shreg_q;
    word_done = 1'b0;
    strobe    = SAMPLE_STB & CS_ACTIVE;

    case (state_q)
      IDLE:    if (CS_ACTIVE)  state_d = SHIFT;
      SHIFT:   if (!CS_ACTIVE) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (!CS_ACTIVE) begin
      cnt_d   = '0;
      shreg_d = '0;
    end else if (strobe) begin
      push_word = shift_in(shreg_q, MISO, LSB_FIRST);
      shreg_d   = push_word;
      if (cnt_q == LAST_BIT) begin
        word_done = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // FIFO control: a full FIFO still accepts a word when a pop frees the slot in the same cycle
  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    pop      = RD_EN & ~empty;
    push     = word_done & (~full | RD_EN);
    drop     = word_done & full & ~RD_EN;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    if (drop)         ovr_d = 1'b1;
    else if (OVR_CLR) ovr_d = 1'b0;
    else              ovr_d = ovr_q;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovr_q    <= ovr_d;
    end
  end

  // Storage holds data only; validity comes from the pointers, so it needs no reset
  always_ff @(posedge PCLK) begin
    if (PRESETn && push) mem[wr_ptr_q[AW-1:0]] <= push_word;
  end

  assign RD_DATA      = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  assign RXFIFO_FULL  = full;
  assign RXFIFO_EMPTY = empty;
  assign RX_LEVEL     = wr_ptr_q - rd_ptr_q;
  assign RX_OVERRUN   = ovr_q;

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Bench for spi_rx_fifo: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a queue-based model of the receiver.
module tb_spi_rx_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cs = 1'b0, stb = 1'b0, miso = 1'b0, lsb = 1'b0, rd = 1'b0, clr = 1'b0;
  logic [7:0] rd_data;
  logic       full, empty, ovr;
  logic [2:0] level;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  spi_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .PCLK(clk), .PRESETn(rstn), .CS_ACTIVE(cs), .SAMPLE_STB(stb), .MISO(miso),
    .LSB_FIRST(lsb), .RD_EN(rd), .OVR_CLR(clr), .RD_DATA(rd_data),
    .RXFIFO_FULL(full), .RXFIFO_EMPTY(empty), .RX_LEVEL(level), .RX_OVERRUN(ovr)
  );

  always #5 clk = ~clk;

  // Reference model: bits are placed by position within the word, words kept in a queue
  logic [7:0] m_q[$];
  int         m_cnt = 0;
  logic [7:0] m_word = '0;
  logic       m_ovr = 1'b0;

  always @(posedge clk) begin
    bit         done, drop;
    logic [7:0] w;
    done = 0; drop = 0; w = '0;
    if (!rstn) begin
      m_q.delete(); m_cnt = 0; m_word = '0; m_ovr = 1'b0;
    end else begin
      if (!cs) begin
        m_cnt = 0; m_word = '0;
      end else if (stb) begin
        if (lsb) m_word[m_cnt] = miso;
        else     m_word[DATA_W-1-m_cnt] = miso;
        if (m_cnt == DATA_W-1) begin
          done = 1; w = m_word; m_cnt = 0; m_word = '0;
        end else m_cnt++;
      end
      drop = done && (m_q.size() == DEPTH) && !rd;
      if (rd && m_q.size() > 0) void'(m_q.pop_front());
      if (done && !drop) m_q.push_back(w);
      if (drop) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] head;
    int         n;
    if (chk_en) begin
      n    = m_q.size();
      head = (n > 0) ? m_q[0] : 8'h00;
      chk("rd_data", {24'd0, rd_data}, {24'd0, head});
      chk("level",   {29'd0, level},   n);
      chk("full",    {31'd0, full},    {31'd0, n == DEPTH});
      chk("empty",   {31'd0, empty},   {31'd0, n == 0});
      chk("overrun", {31'd0, ovr},     {31'd0, m_ovr});
    end
  end

  // Inputs are set just after the rising edge, so one call equals one PCLK cycle
  task automatic cyc(input logic s, input logic b);
    stb = s; miso = b;
    @(posedge clk); #1;
    stb = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] v, input logic l, input logic rd_last, input logic clr_last);
    lsb = l;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == DATA_W-1) begin rd = rd_last; clr = clr_last; end
      cyc(1'b1, l ? v[i] : v[DATA_W-1-i]);
    end
  endtask

  task automatic pop1();
    rd = 1'b1; cyc(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rstn = 1'b0; cyc(1'b0, 1'b0); rstn = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();
    chk_en = 1'b1;
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_data",  {24'd0, rd_data}, 32'h0);

    // MSB-first word
    cs = 1'b1;
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    chk("t1_data",  {24'd0, rd_data}, 32'hA5);
    chk("t1_level", {29'd0, level}, 32'd1);
    chk("t1_empty", {31'd0, empty}, 32'd0);
    pop1();

    // LSB-first words
    send_word(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("t2_pal", {24'd0, rd_data}, 32'hA5);
    pop1();
    send_word(8'h03, 1'b1, 1'b0, 1'b0);
    chk("t2_03", {24'd0, rd_data}, 32'h03);
    pop1();

    // Fill, overrun, drain
    send_word(8'h11, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0);
    send_word(8'h33, 1'b0, 1'b0, 1'b0);
    send_word(8'h44, 1'b0, 1'b0, 1'b0);
    chk("t3_full",  {31'd0, full}, 32'd1);
    chk("t3_level", {29'd0, level}, 32'd4);
    send_word(8'h55, 1'b0, 1'b0, 1'b0);
    chk("t3_ovr",   {31'd0, ovr}, 32'd1);
    chk("t3_head",  {24'd0, rd_data}, 32'h11);
    pop1(); chk("t3_pop1", {24'd0, rd_data}, 32'h22);
    pop1(); chk("t3_pop2", {24'd0, rd_data}, 32'h33);
    pop1(); chk("t3_pop3", {24'd0, rd_data}, 32'h44);
    pop1();
    chk("t3_empty", {31'd0, empty}, 32'd1);
    chk("t3_zero",  {24'd0, rd_data}, 32'h0);
    clr = 1'b1; cyc(1'b0, 1'b0);
    chk("t3_clr", {31'd0, ovr}, 32'd0);

    // Push into full FIFO with simultaneous pop
    send_word(8'h11, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0);
    send_word(8'h33, 1'b0, 1'b0, 1'b0);
    send_word(8'h44, 1'b0, 1'b0, 1'b0);
    send_word(8'h66, 1'b0, 1'b1, 1'b0);
    chk("t4_level", {29'd0, level}, 32'd4);
    chk("t4_ovr",   {31'd0, ovr}, 32'd0);
    chk("t4_head",  {24'd0, rd_data}, 32'h22);
    pop1(); pop1(); pop1();
    chk("t4_tail", {24'd0, rd_data}, 32'h66);
    pop1();

    // Aborted frame, then reset mid-word with overrun set
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
    cs = 1'b0; cyc(1'b0, 1'b0);
    cs = 1'b1;
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    chk("t5_data",  {24'd0, rd_data}, 32'h3C);
    chk("t5_level", {29'd0, level}, 32'd1);
    for (int i = 0; i < 4; i++) send_word(8'h90 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("t5_ovr_set", {31'd0, ovr}, 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
    do_reset();
    chk("t5_rst_level", {29'd0, level}, 32'd0);
    chk("t5_rst_ovr",   {31'd0, ovr}, 32'd0);
    send_word(8'h5A, 1'b0, 1'b0, 1'b0);
    chk("t5_clean_word", {24'd0, rd_data}, 32'h5A);
    pop1();

    // Pop while empty; clear coinciding with a drop
    pop1();
    chk("t6_lvl0",  {29'd0, level}, 32'd0);
    chk("t6_data0", {24'd0, rd_data}, 32'h0);
    for (int i = 0; i < 4; i++) send_word(8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
    send_word(8'hEE, 1'b0, 1'b0, 1'b1);
    chk("t6_ovr_wins", {31'd0, ovr}, 32'd1);
    chk("t6_head",     {24'd0, rd_data}, 32'hC0);
    clr = 1'b1; cyc(1'b0, 1'b0);
    chk("t6_ovr_clr", {31'd0, ovr}, 32'd0);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) cs = ~cs;
      else if (!cs && $urandom_range(0, 9) == 0) cs = 1'b1;
      if (m_cnt == 0 && $urandom_range(0, 3) == 0) lsb = $urandom_range(0, 1) == 1;
      rd  = $urandom_range(0, 5) == 0;
      clr = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 999) == 0) do_reset();
      else cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
